// File: rtl/instr_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// The request and address are held stable by the master until the slave acknowledges.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 8
) ();
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 32-bit datapath.
// Owns the program counter and instruction register, fetches over a req/ack bus,
// and turns the decoder's level write enables into one-instruction-at-a-time strobes.
// Every output comes straight from a register, so dec_* never reach fetch-side outputs.
module instr_sequencer #(
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] PC_RESET    = '0,
  parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  instr_sequencer_if.master        imem,
  output logic [31:0]              ir,
  input  logic                     dec_rwe,
  input  logic                     dec_rwe2,
  input  logic                     dec_mwe,
  input  logic                     dmem_ack,
  output logic                     rwe_o,
  output logic                     rwe2_o,
  output logic                     mwe_o,
  output logic                     busy,
  output logic                     halted,
  output logic [15:0]              instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_ir;
  logic [15:0]         r_instr_count;
  logic                r_imem_req;
  logic                r_rwe;
  logic                r_rwe2;
  logic                r_mwe;
  logic                r_busy;
  logic                r_halted;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET;
      r_ir          <= '0;
      r_instr_count <= '0;
      r_imem_req    <= 1'b0;
      r_rwe         <= 1'b0;
      r_rwe2        <= 1'b0;
      r_mwe         <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          // Request and address stay put until the memory answers.
          if (imem.imem_ack) begin
            r_ir       <= imem.imem_rdata;
            r_pc       <= r_pc + PC_WIDTH'(1);
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Settle cycle for the combinational decoder; halt is not retired.
          if (r_ir[31:26] == HALT_OPCODE) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Stores take priority over register writes.
          if (dec_mwe) begin
            r_mwe   <= 1'b1;
            r_state <= S_MEM;
          end else if (dec_rwe || dec_rwe2) begin
            r_rwe   <= dec_rwe;
            r_rwe2  <= dec_rwe2;
            r_state <= S_WB;
          end else begin
            r_instr_count <= sat_inc16(r_instr_count);
            r_imem_req    <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_mwe         <= 1'b0;
            r_instr_count <= sat_inc16(r_instr_count);
            r_imem_req    <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        S_WB: begin
          r_rwe         <= 1'b0;
          r_rwe2        <= 1'b0;
          r_instr_count <= sat_inc16(r_instr_count);
          r_imem_req    <= 1'b1;
          r_state       <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            r_pc       <= PC_RESET;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_pc;
  assign ir             = r_ir;
  assign rwe_o          = r_rwe;
  assign rwe2_o         = r_rwe2;
  assign mwe_o          = r_mwe;
  assign busy           = r_busy;
  assign halted         = r_halted;
  assign instr_count    = r_instr_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: small program memory, simple decoder model,
// configurable fetch/store acknowledge delays and strobe counters.
module tb_instr_sequencer;

  localparam int PC_WIDTH = 8;

  localparam logic [31:0] OP_NOP   = 32'h0000_0000;
  localparam logic [31:0] OP_ADD   = {6'b000001, 26'h0000123};
  localparam logic [31:0] OP_SUB   = {6'b000010, 26'h0000456};
  localparam logic [31:0] OP_MOV   = {6'b000011, 26'h0000789};
  localparam logic [31:0] OP_STORE = {6'b000100, 26'h0000ABC};
  localparam logic [31:0] OP_HALT  = {6'b111111, 26'h0000000};

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] ir;
  logic        dec_rwe, dec_rwe2, dec_mwe;
  logic        dmem_ack;
  logic        rwe_o, rwe2_o, mwe_o;
  logic        busy, halted;
  logic [15:0] instr_count;

  instr_sequencer_if #(.PC_WIDTH(PC_WIDTH)) imem ();

  instr_sequencer #(
    .PC_WIDTH   (PC_WIDTH),
    .PC_RESET   (8'h00),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem       (imem.master),
    .ir         (ir),
    .dec_rwe    (dec_rwe),
    .dec_rwe2   (dec_rwe2),
    .dec_mwe    (dec_mwe),
    .dmem_ack   (dmem_ack),
    .rwe_o      (rwe_o),
    .rwe2_o     (rwe2_o),
    .mwe_o      (mwe_o),
    .busy       (busy),
    .halted     (halted),
    .instr_count(instr_count)
  );

  // Decoder model driven from the instruction register.
  assign dec_rwe  = (ir[31:26] == 6'b000001) || (ir[31:26] == 6'b000010);
  assign dec_rwe2 = (ir[31:26] == 6'b000011);
  assign dec_mwe  = (ir[31:26] == 6'b000100);

  logic [31:0] prog [256];
  int          fetch_wait;
  int          dmem_delay;
  int          fcnt, dcnt;
  logic        auto_ack, auto_dack;
  logic [31:0] auto_rdata;
  logic        man_mode, man_ack;
  logic [31:0] man_rdata;

  assign imem.imem_ack   = man_mode ? man_ack   : auto_ack;
  assign imem.imem_rdata = man_mode ? man_rdata : auto_rdata;
  assign dmem_ack        = auto_dack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rwe    = 0;
  int n_rwe2   = 0;
  int n_mwe    = 0;
  int rwe_last = 0;
  int rwe_prev = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responders: answer on the falling edge so the DUT sees ack at the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      auto_ack   = 1'b0;
      auto_dack  = 1'b0;
      auto_rdata = 32'h0;
      fcnt       = 0;
      dcnt       = 0;
    end else begin
      if (imem.imem_req) begin
        if (fcnt >= fetch_wait) begin
          auto_ack   = 1'b1;
          auto_rdata = prog[imem.imem_addr];
          fcnt       = 0;
        end else begin
          auto_ack = 1'b0;
          fcnt     = fcnt + 1;
        end
      end else begin
        auto_ack = 1'b0;
      end
      if (mwe_o) begin
        if (dcnt >= dmem_delay - 1) begin
          auto_dack = 1'b1;
          dcnt      = 0;
        end else begin
          auto_dack = 1'b0;
          dcnt      = dcnt + 1;
        end
      end else begin
        auto_dack = 1'b0;
        dcnt      = 0;
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rwe_o) begin
      n_rwe    = n_rwe + 1;
      rwe_prev = rwe_last;
      rwe_last = cyc;
    end
    if (rwe2_o) n_rwe2 = n_rwe2 + 1;
    if (mwe_o)  n_mwe  = n_mwe + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input int lim, output int ncyc);
    ncyc = 0;
    while (!halted && ncyc < lim) begin
      @(negedge clk);
      ncyc = ncyc + 1;
    end
    if (!halted) chk_eq("halt_timeout", 32'(halted), 32'd1);
  endtask

  int lat;
  int snap_rwe, snap_rwe2, snap_mwe;
  int guard;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    man_mode   = 1'b0;
    man_ack    = 1'b0;
    man_rdata  = 32'h0;
    fetch_wait = 0;
    dmem_delay = 1;
    for (int i = 0; i < 256; i++) prog[i] = OP_NOP;

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst_req",    32'(imem.imem_req),  32'd0);
    chk_eq("rst_addr",   32'(imem.imem_addr), 32'd0);
    chk_eq("rst_ir",     ir,                  32'd0);
    chk_eq("rst_busy",   32'(busy),           32'd0);
    chk_eq("rst_halted", 32'(halted),         32'd0);
    chk_eq("rst_cnt",    32'(instr_count),    32'd0);
    chk_eq("rst_strobe", 32'({rwe_o, rwe2_o, mwe_o}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("idle_busy",  32'(busy),           32'd0);

    // ADD, SUB, HALT with zero-wait fetch
    prog[0] = OP_ADD; prog[1] = OP_SUB; prog[2] = OP_HALT;
    snap_rwe = n_rwe; snap_rwe2 = n_rwe2; snap_mwe = n_mwe;
    pulse_start();
    chk_eq("start_req",  32'(imem.imem_req),  32'd1);
    chk_eq("start_busy", 32'(busy),           32'd1);
    wait_halted(50, lat);
    chk_eq("p1_latency", 32'(lat),            32'd10);
    chk_eq("p1_cnt",     32'(instr_count),    32'd2);
    chk_eq("p1_pc",      32'(imem.imem_addr), 32'd3);
    chk_eq("p1_halted",  32'(halted),         32'd1);
    chk_eq("p1_busy",    32'(busy),           32'd0);
    chk_eq("p1_rwe_n",   32'(n_rwe - snap_rwe),   32'd2);
    chk_eq("p1_rwe_gap", 32'(rwe_last - rwe_prev), 32'd4);
    chk_eq("p1_rwe2_n",  32'(n_rwe2 - snap_rwe2), 32'd0);
    chk_eq("p1_mwe_n",   32'(n_mwe - snap_mwe),   32'd0);

    // MOV
    do_reset();
    prog[0] = OP_MOV; prog[1] = OP_HALT;
    snap_rwe = n_rwe; snap_rwe2 = n_rwe2;
    pulse_start();
    wait_halted(50, lat);
    chk_eq("mov_rwe2_n", 32'(n_rwe2 - snap_rwe2), 32'd1);
    chk_eq("mov_rwe_n",  32'(n_rwe - snap_rwe),   32'd0);
    chk_eq("mov_cnt",    32'(instr_count),        32'd1);

    // Store with dmem_ack on the third MEM cycle
    do_reset();
    prog[0] = OP_STORE; prog[1] = OP_HALT;
    dmem_delay = 3;
    snap_mwe = n_mwe; snap_rwe = n_rwe;
    pulse_start();
    wait_halted(50, lat);
    chk_eq("st_mwe_n",   32'(n_mwe - snap_mwe), 32'd3);
    chk_eq("st_latency", 32'(lat),              32'd8);
    chk_eq("st_cnt",     32'(instr_count),      32'd1);
    chk_eq("st_rwe_n",   32'(n_rwe - snap_rwe), 32'd0);
    dmem_delay = 1;

    // Fetch acknowledge withheld for five cycles, start pulsed meanwhile
    do_reset();
    prog[0] = OP_ADD; prog[1] = OP_HALT;
    man_mode = 1'b1;
    man_ack  = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk_eq("fw_req",  32'(imem.imem_req),  32'd1);
      chk_eq("fw_addr", 32'(imem.imem_addr), 32'd0);
      chk_eq("fw_ir",   ir,                  32'd0);
      start = (i % 2 == 0);
      @(negedge clk);
    end
    start     = 1'b0;
    man_rdata = OP_ADD;
    man_ack   = 1'b1;
    @(negedge clk);
    man_ack  = 1'b0;
    chk_eq("fw_ir_ack",  ir,                  OP_ADD);
    chk_eq("fw_req_ack", 32'(imem.imem_req),  32'd0);
    chk_eq("fw_pc_ack",  32'(imem.imem_addr), 32'd1);
    man_mode = 1'b0;
    wait_halted(50, lat);
    chk_eq("fw_cnt",     32'(instr_count),    32'd1);

    // PC wrap through 8'hFF
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = OP_NOP;
    pulse_start();
    guard = 0;
    while (!(imem.imem_req && imem.imem_addr == 8'hFF) && guard < 2000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    chk_eq("wrap_reach_ff", 32'(imem.imem_addr), 32'hFF);
    guard = 0;
    while (imem.imem_req && guard < 20) begin
      @(negedge clk);
      guard = guard + 1;
    end
    chk_eq("wrap_pc", 32'(imem.imem_addr), 32'd0);
    prog[1] = OP_HALT;
    wait_halted(50, lat);
    chk_eq("wrap_cnt", 32'(instr_count), 32'd257);
    chk_eq("wrap_pc_end", 32'(imem.imem_addr), 32'd2);

    // Counter saturation, and restart from HALT resets pc
    force dut.r_instr_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_instr_count;
    prog[0] = OP_NOP; prog[1] = OP_NOP; prog[2] = OP_HALT;
    pulse_start();
    chk_eq("restart_pc", 32'(imem.imem_addr), 32'd0);
    wait_halted(50, lat);
    chk_eq("sat_cnt", 32'(instr_count), 32'hFFFF);
    chk_eq("sat_pc",  32'(imem.imem_addr), 32'd3);

    // Reset asserted during WB
    do_reset();
    prog[0] = OP_ADD; prog[1] = OP_HALT;
    pulse_start();
    guard = 0;
    while (!rwe_o && guard < 20) begin
      @(negedge clk);
      guard = guard + 1;
    end
    chk_eq("wbr_in_wb", 32'(rwe_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("wbr_rwe",  32'(rwe_o),          32'd0);
    chk_eq("wbr_busy", 32'(busy),           32'd0);
    chk_eq("wbr_cnt",  32'(instr_count),    32'd0);
    chk_eq("wbr_ir",   ir,                  32'd0);
    chk_eq("wbr_pc",   32'(imem.imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap_rwe = n_rwe;
    repeat (6) @(negedge clk);
    chk_eq("wbr_idle_req",  32'(imem.imem_req), 32'd0);
    chk_eq("wbr_idle_busy", 32'(busy),          32'd0);
    chk_eq("wbr_idle_rwe",  32'(n_rwe - snap_rwe), 32'd0);

    // Reset asserted during MEM
    prog[0] = OP_STORE; prog[1] = OP_HALT;
    dmem_delay = 10;
    pulse_start();
    guard = 0;
    while (!mwe_o && guard < 20) begin
      @(negedge clk);
      guard = guard + 1;
    end
    chk_eq("mr_in_mem", 32'(mwe_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("mr_mwe",    32'(mwe_o),       32'd0);
    chk_eq("mr_busy",   32'(busy),        32'd0);
    chk_eq("mr_cnt",    32'(instr_count), 32'd0);
    chk_eq("mr_halted", 32'(halted),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap_mwe = n_mwe;
    repeat (6) @(negedge clk);
    chk_eq("mr_idle_mwe",  32'(n_mwe - snap_mwe), 32'd0);
    chk_eq("mr_idle_req",  32'(imem.imem_req),    32'd0);
    chk_eq("mr_idle_cnt",  32'(instr_count),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
